// File: rtl/m_fetch_queue_pkg.sv
// Constants shared by the instruction fetch queue and its FIFO.
package m_fetch_queue_pkg;
    localparam logic [31:0] HALT_INSTR_WORD = 32'h000f0033;
    localparam logic [31:0] NOP_INSTR       = 32'h00000013;
    localparam int unsigned IMEM_AW         = 12;
endpackage

// File: rtl/m_fetch_fifo.sv
// Generic show-ahead FIFO with synchronous flush; the head reads as zero when empty.
module m_fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked by count.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign valid_o = (count_q != '0);
    assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;
endmodule

// File: rtl/m_fetch_queue.sv
// Instruction fetch front end: issues word addresses to a synchronous memory and
// queues returned {pc, instr} pairs for decode, with redirect and halt handling.
module m_fetch_queue
    import m_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter logic [31:0] HALT_INSTR = HALT_INSTR_WORD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    input  logic               deq_ready,
    output logic               deq_valid,
    output logic [31:0]        deq_instr,
    output logic [31:0]        deq_pc,
    output logic               halted
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("m_fetch_queue: DEPTH must be a power of two and at least 2");
    end

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic          halted_q, halted_d;
    logic [CW-1:0] fifo_count;
    logic          fifo_valid;
    logic [63:0]   fifo_rdata;
    logic          halt_hit, issue, push, pop, flush;

    // Stop issuing on the very edge the halt word is captured, so nothing past it is fetched.
    assign halt_hit = inflight_q && (imem_data == HALT_INSTR);
    assign issue    = ce && !redirect && !halted_q && !halt_hit
                      && ((32'(fifo_count) + 32'(inflight_q)) < DEPTH);
    assign push     = ce && !redirect && inflight_q;
    assign pop      = ce && !redirect && fifo_valid && deq_ready;
    assign flush    = ce && redirect;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        halted_d      = halted_q;
        if (ce) begin
            if (redirect) begin
                fetch_pc_d = redirect_pc;
                inflight_d = 1'b0;
                halted_d   = 1'b0;
            end else begin
                inflight_d = issue;
                if (issue) begin
                    fetch_pc_d    = fetch_pc_q + 32'd4;
                    inflight_pc_d = fetch_pc_q;
                end
                if (halt_hit) halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            halted_q      <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            halted_q      <= halted_d;
        end
    end

    m_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({inflight_pc_q, imem_data}),
        .valid_o (fifo_valid),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

    assign imem_addr = fetch_pc_q[IMEM_AW+1:2];
    assign deq_valid = fifo_valid;
    assign deq_pc    = fifo_rdata[63:32];
    assign deq_instr = fifo_rdata[31:0];
    assign halted    = halted_q;
endmodule

// File: tb/tb_m_fetch_queue.sv
// Directed bench for m_fetch_queue: streaming, backpressure, redirect, halt, reset and a
// random ce/deq_ready run checked against the sequential pc stream.
module tb_m_fetch_queue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [11:0] imem_addr;
    logic [31:0] imem_data;
    logic        deq_ready;
    logic        deq_valid;
    logic [31:0] deq_instr;
    logic [31:0] deq_pc;
    logic        halted;

    logic [31:0] mem [4096];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;

    localparam logic [31:0] HALT = 32'h000f0033;

    m_fetch_queue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce          (ce),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .deq_ready   (deq_ready),
        .deq_valid   (deq_valid),
        .deq_instr   (deq_instr),
        .deq_pc      (deq_pc),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory sharing the fetch clock enable.
    always @(posedge clk) begin
        if (ce) imem_data <= mem[imem_addr];
    end

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return 32'hA000_0000 | {20'h0, pc[13:2]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 | 32'(i);
        rst_n = 1'b0; ce = 1'b1; redirect = 1'b0; redirect_pc = '0; deq_ready = 1'b0;
        step();
        step();
        chk("rst_valid", 32'(deq_valid), 32'd0);
        chk("rst_pc", deq_pc, 32'd0);
        chk("rst_instr", deq_instr, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);

        // Stream from reset: first entry visible after the second edge.
        rst_n = 1'b1; deq_ready = 1'b1;
        step();
        chk("first_edge_valid", 32'(deq_valid), 32'd0);
        chk("first_edge_addr", 32'(imem_addr), 32'd1);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("stream_valid", 32'(deq_valid), 32'd1);
            chk("stream_pc", deq_pc, 32'(4 * k));
            chk("stream_instr", deq_instr, word_at(32'(4 * k)));
        end

        // Backpressure for 10 cycles: queue fills, issue stops at word 9.
        deq_ready = 1'b0;
        step(); step(); step();
        chk("stall_addr_full", 32'(imem_addr), 32'd9);
        for (int k = 0; k < 7; k++) step();
        chk("stall_addr_held", 32'(imem_addr), 32'd9);
        chk("stall_head_pc", deq_pc, 32'h14);
        chk("stall_valid", 32'(deq_valid), 32'd1);
        deq_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("resume_pc", deq_pc, 32'h18 + 32'(4 * k));
            chk("resume_instr", deq_instr, word_at(32'h18 + 32'(4 * k)));
        end

        // Fill the queue, then redirect to 0x100.
        deq_ready = 1'b0;
        step(); step(); step();
        chk("full_head_pc", deq_pc, 32'h34);
        redirect = 1'b1; redirect_pc = 32'h100; deq_ready = 1'b1;
        step();
        redirect = 1'b0;
        chk("redir_empty", 32'(deq_valid), 32'd0);
        chk("redir_pc_zero", deq_pc, 32'd0);
        chk("redir_addr", 32'(imem_addr), 32'h40);
        step();
        chk("redir_e1_valid", 32'(deq_valid), 32'd0);
        step();
        chk("redir_e2_valid", 32'(deq_valid), 32'd1);
        chk("redir_e2_pc", deq_pc, 32'h100);
        chk("redir_e2_instr", deq_instr, word_at(32'h100));
        step();
        chk("redir_next_pc", deq_pc, 32'h104);

        // Redirect with a fetch in flight: the in-flight word must be dropped.
        redirect = 1'b1; redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        chk("drop_empty", 32'(deq_valid), 32'd0);
        step();
        chk("drop_e1_valid", 32'(deq_valid), 32'd0);
        step();
        chk("drop_e2_pc", deq_pc, 32'h200);

        // Halt word at 0x20.
        mem[8] = HALT;
        redirect = 1'b1; redirect_pc = 32'h18;
        step();
        redirect = 1'b0;
        chk("halt_pre", 32'(halted), 32'd0);
        step(); step();
        chk("halt_head0", deq_pc, 32'h18);
        step();
        chk("halt_not_yet", 32'(halted), 32'd0);
        step();
        chk("halt_set", 32'(halted), 32'd1);
        chk("halt_head_pc", deq_pc, 32'h20);
        chk("halt_head_instr", deq_instr, HALT);
        chk("halt_addr", 32'(imem_addr), 32'd9);
        step(); step(); step();
        chk("halt_drained", 32'(deq_valid), 32'd0);
        chk("halt_sticky", 32'(halted), 32'd1);
        chk("halt_addr_held", 32'(imem_addr), 32'd9);

        // Redirect out of halt.
        redirect = 1'b1; redirect_pc = 32'h300;
        step();
        redirect = 1'b0;
        chk("unhalt", 32'(halted), 32'd0);
        chk("unhalt_addr", 32'(imem_addr), 32'hC0);
        step(); step();
        chk("unhalt_pc", deq_pc, 32'h300);
        chk("unhalt_instr", deq_instr, word_at(32'h300));
        mem[8] = word_at(32'h20);
        step();

        // Asynchronous reset mid-stream.
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(deq_valid), 32'd0);
        chk("async_pc", deq_pc, 32'd0);
        chk("async_addr", 32'(imem_addr), 32'd0);
        step();
        rst_n = 1'b1; ce = 1'b0;
        step();
        chk("post_rst_ce0_addr", 32'(imem_addr), 32'd0);
        chk("post_rst_ce0_valid", 32'(deq_valid), 32'd0);

        // Random ce / deq_ready; delivered pcs must be 0,4,8,... with no gaps or repeats.
        exp_pc = 32'd0;
        for (int n = 0; n < 400; n++) begin
            ce = ($urandom_range(0, 3) != 0);
            deq_ready = ($urandom_range(0, 1) == 1);
            if (ce && deq_ready && deq_valid) begin
                chk("rand_pc", deq_pc, exp_pc);
                chk("rand_instr", deq_instr, word_at(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
            step();
        end
        chk("rand_progress", 32'(exp_pc >= 32'h80), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/m_fetch_queue.md
M_FETCH_QUEUE -- requirements
Module: m_fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving queue entries; it SHALL be a power of two and at least 2.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0, giving the first fetch address after reset.
REQ-003 The block SHALL have parameter HALT_INSTR, default 32'h000f0033, giving the instruction word that stops fetching.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 ce  in  1  clock enable; when 0, all state is held.
REQ-007 redirect  in  1  flush queue and restart fetch; driven by the branch-resolving stage.
REQ-008 redirect_pc  in  32  new fetch address, valid while redirect=1.
REQ-009 imem_addr  out  12  word address to the synchronous instruction memory, equal to fetch_pc[13:2].
REQ-010 imem_data  in  32  memory read data, valid one edge after imem_addr is sampled.
REQ-011 deq_ready  in  1  decode accepts the head entry.
REQ-012 deq_valid  out  1  head entry is valid.
REQ-013 deq_instr  out  32  head instruction.
REQ-014 deq_pc  out  32  head instruction address.
REQ-015 halted  out  1  HALT_INSTR has been captured; fetching is stopped.

Function
REQ-016 The state SHALL be fetch_pc, an inflight flag with its pc, a DEPTH-entry FIFO of {pc, instr}, rd_ptr, wr_ptr, count (0..DEPTH) and halted.
REQ-017 issue = ce & ~redirect & ~halted & (count + inflight < DEPTH); on issue, fetch_pc SHALL become fetch_pc+4, inflight SHALL be set to 1 and inflight_pc SHALL take fetch_pc; otherwise inflight SHALL be cleared at a ce edge.
REQ-018 At a ce edge with inflight=1 and redirect=0, {inflight_pc, imem_data} SHALL be written at wr_ptr, and wr_ptr SHALL advance modulo DEPTH.
REQ-019 A dequeue SHALL occur when deq_valid & deq_ready & ce & ~redirect; rd_ptr SHALL advance modulo DEPTH.
REQ-020 deq_valid SHALL be (count != 0), and deq_instr/deq_pc SHALL be taken from the entry at rd_ptr (show-ahead); when the queue is empty, deq_instr and deq_pc SHALL be 0.
REQ-021 On a simultaneous write and dequeue, count SHALL be unchanged; overflow SHALL be impossible given the credit rule in REQ-017.
REQ-022 When redirect=1 at a ce edge: count, pointers, inflight and halted SHALL clear, fetch_pc SHALL be loaded with redirect_pc, and any returning imem_data SHALL be dropped; redirect SHALL take priority over write and dequeue.
REQ-023 If the captured imem_data equals HALT_INSTR, the entry SHALL be enqueued and halted SHALL be set; halted SHALL clear only on redirect or reset.
REQ-024 Latency: an address issued at edge E SHALL appear on deq at E+1; redirect at edge E SHALL give a first new deq_valid after E+2; sustained throughput SHALL be 1 instruction/cycle while deq_ready=1.
REQ-025 When ce=0, fetch_pc and imem_addr SHALL be held, so that memory re-read data stays stable.

Reset
REQ-026 On rst_n=0, asynchronously: fetch_pc=RESET_PC, count=0, rd_ptr=wr_ptr=0, inflight=0, halted=0, deq_valid=0, deq_instr=0, deq_pc=0.
REQ-027 If reset is asserted mid-operation, all queued and inflight data SHALL be discarded; the first issue SHALL occur at the first ce edge after rst_n rises.

Structure
REQ-028 A shared package SHALL hold HALT_INSTR, the NOP encoding 32'h00000013, and the memory word-index width of 12.
REQ-029 One sub-module, m_fetch_fifo (generic DEPTH x 64-bit show-ahead FIFO with synchronous flush), SHALL be instantiated.

Verification
REQ-030 Reset release, deq_ready=1, memory holding sequential words -> deq_pc 0,4,8,... one per cycle from the second edge after release.
REQ-031 deq_ready=0 for 10 cycles -> count saturates at 4, issue stops, and no entry is lost or duplicated after deq_ready returns to 1.
REQ-032 redirect with redirect_pc=32'h100 while the queue is full -> queue empty at the next edge, inflight data dropped, next deq_pc=32'h100.
REQ-033 Memory word at 32'h20 = 32'h000f0033 -> the entry at 32'h20 is delivered, halted=1, and no imem_addr beyond word 8 is issued.
REQ-034 Redirect while halted=1 -> halted=0 and fetch resumes at redirect_pc.
REQ-035 ce toggled randomly with deq_ready toggled randomly -> the delivered pc stream matches the reference sequence exactly.
